// File: rtl/fc3_argmax.sv
// Streaming argmax over the NCLS class scores of one fc3 frame; reports the winning index.
// Optional macro FC3_ARGMAX_SCORE_EN adds an oScore port carrying the winning score.
module fc3_argmax #(
    parameter int NCLS = 10,
    parameter int DWID = 22,
    parameter int CWID = (NCLS > 1) ? $clog2(NCLS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iValid,
    input  logic [DWID-1:0] iData,
    output logic            iReady,
    output logic            oValid,
    output logic [CWID-1:0] oClass,
    input  logic            oReady
`ifdef FC3_ARGMAX_SCORE_EN
    ,
    output logic [DWID-1:0] oScore
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [CWID-1:0] LAST_IDX = CWID'(NCLS - 1);

    state_t          state;
    logic [CWID-1:0] cnt;
    logic [DWID-1:0] max_r;
    logic [CWID-1:0] idx_r;
    logic            ready_r;
    logic            valid_r;
    logic            accept;

    // Handshake uses only the registered ready, so iValid never reaches iReady.
    assign accept = iValid && ready_r;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            max_r   <= '0;
            idx_r   <= '0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        max_r <= iData;
                        idx_r <= '0;
                        if (NCLS == 1) begin
                            state   <= DONE;
                            cnt     <= '0;
                            ready_r <= 1'b0;
                            valid_r <= 1'b1;
                        end else begin
                            state <= SCAN;
                            cnt   <= CWID'(1);
                        end
                    end
                end
                SCAN: begin
                    if (accept) begin
                        // Strictly-greater compare keeps the lowest index on ties.
                        if (iData > max_r) begin
                            max_r <= iData;
                            idx_r <= cnt;
                        end
                        if (cnt == LAST_IDX) begin
                            state   <= DONE;
                            cnt     <= '0;
                            ready_r <= 1'b0;
                            valid_r <= 1'b1;
                        end else begin
                            cnt <= cnt + CWID'(1);
                        end
                    end
                end
                DONE: begin
                    if (oReady) begin
                        state   <= IDLE;
                        ready_r <= 1'b1;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign iReady = ready_r;
    assign oValid = valid_r;
    assign oClass = idx_r;
`ifdef FC3_ARGMAX_SCORE_EN
    assign oScore = max_r;
`endif

endmodule

// File: tb/tb_fc3_argmax.sv
// Directed bench for fc3_argmax: a 10-class instance and a 1-class instance.
module tb_fc3_argmax;

    localparam int DWID = 22;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            iValid;
    logic [DWID-1:0] iData;
    logic            iReady;
    logic            oValid;
    logic [3:0]      oClass;
    logic            oReady;

    logic            iValid1;
    logic [DWID-1:0] iData1;
    logic            iReady1;
    logic            oValid1;
    logic [0:0]      oClass1;
    logic            oReady1;

`ifdef FC3_ARGMAX_SCORE_EN
    logic [DWID-1:0] oScore;
    logic [DWID-1:0] oScore1;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fc3_argmax #(.NCLS(10), .DWID(DWID)) u_dut (
        .clk(clk), .rst_n(rst_n), .iValid(iValid), .iData(iData), .iReady(iReady),
        .oValid(oValid), .oClass(oClass), .oReady(oReady)
`ifdef FC3_ARGMAX_SCORE_EN
        , .oScore(oScore)
`endif
    );

    fc3_argmax #(.NCLS(1), .DWID(DWID)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .iValid(iValid1), .iData(iData1), .iReady(iReady1),
        .oValid(oValid1), .oClass(oClass1), .oReady(oReady1)
`ifdef FC3_ARGMAX_SCORE_EN
        , .oScore(oScore1)
`endif
    );

    // Called at a negedge; returns at the next negedge with the post-edge state visible.
    task automatic push(input logic [DWID-1:0] d);
        iValid = 1'b1;
        iData  = d;
        @(negedge clk);
        iValid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iValid = 1'b0; iData = '0; oReady = 1'b1;
        iValid1 = 1'b0; iData1 = '0; oReady1 = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (oValid !== 1'b0) begin n_err++; $display("FAIL reset_ovalid: got %0b want 0", oValid); end
        n_vec++; if (oClass !== 4'd0) begin n_err++; $display("FAIL reset_oclass: got %0d want 0", oClass); end
        n_vec++; if (iReady !== 1'b1) begin n_err++; $display("FAIL reset_iready: got %0b want 1", iReady); end
        n_vec++; if (oValid1 !== 1'b0) begin n_err++; $display("FAIL reset_ovalid1: got %0b want 0", oValid1); end
`ifdef FC3_ARGMAX_SCORE_EN
        n_vec++; if (oScore !== '0) begin n_err++; $display("FAIL reset_oscore: got %0d want 0", oScore); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [DWID-1:0] s [10] = '{5, 9, 3, 9, 1, 0, 2, 8, 7, 4};
        oReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(s[i]);
            if (i == 8) begin
                n_vec++; if (oValid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %0b want 0", oValid); end
            end
        end
        n_vec++; if (oValid !== 1'b1) begin n_err++; $display("FAIL basic_ovalid: got %0b want 1", oValid); end
        n_vec++; if (oClass !== 4'd1) begin n_err++; $display("FAIL basic_oclass: got %0d want 1", oClass); end
        n_vec++; if (iReady !== 1'b0) begin n_err++; $display("FAIL basic_iready_done: got %0b want 0", iReady); end
`ifdef FC3_ARGMAX_SCORE_EN
        n_vec++; if (oScore !== 22'd9) begin n_err++; $display("FAIL basic_oscore: got %0d want 9", oScore); end
`endif
        @(negedge clk);
        n_vec++; if (oValid !== 1'b0) begin n_err++; $display("FAIL basic_pulse: got %0b want 0", oValid); end
        n_vec++; if (iReady !== 1'b1) begin n_err++; $display("FAIL basic_iready_back: got %0b want 1", iReady); end
    endtask

    task automatic test_toggle();
        oReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_vec++; if (iReady !== 1'b1) begin n_err++; $display("FAIL toggle_iready[%0d]: got %0b want 1", i, iReady); end
            push(DWID'(i));
            if (i < 9) begin
                n_vec++; if (oValid !== 1'b0) begin n_err++; $display("FAIL toggle_ovalid[%0d]: got %0b want 0", i, oValid); end
                @(negedge clk);
            end
        end
        n_vec++; if (oValid !== 1'b1) begin n_err++; $display("FAIL toggle_ovalid: got %0b want 1", oValid); end
        n_vec++; if (oClass !== 4'd9) begin n_err++; $display("FAIL toggle_oclass: got %0d want 9", oClass); end
        @(negedge clk);
    endtask

    task automatic test_hold();
        logic [DWID-1:0] f1 [10] = '{1, 2, 3, 100, 5, 6, 7, 8, 9, 10};
        logic [DWID-1:0] f2 [10] = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
        oReady = 1'b0;
        for (int i = 0; i < 10; i++) push(f1[i]);
        for (int c = 0; c < 5; c++) begin
            n_vec++; if (oValid !== 1'b1) begin n_err++; $display("FAIL hold_ovalid[%0d]: got %0b want 1", c, oValid); end
            n_vec++; if (oClass !== 4'd3) begin n_err++; $display("FAIL hold_oclass[%0d]: got %0d want 3", c, oClass); end
            n_vec++; if (iReady !== 1'b0) begin n_err++; $display("FAIL hold_iready[%0d]: got %0b want 0", c, iReady); end
`ifdef FC3_ARGMAX_SCORE_EN
            n_vec++; if (oScore !== 22'd100) begin n_err++; $display("FAIL hold_oscore[%0d]: got %0d want 100", c, oScore); end
`endif
            iValid = 1'b1; iData = 22'd4000000;
            @(negedge clk);
        end
        iValid = 1'b0; oReady = 1'b1;
        @(negedge clk);
        n_vec++; if (oValid !== 1'b0) begin n_err++; $display("FAIL hold_release: got %0b want 0", oValid); end
        for (int i = 0; i < 10; i++) push(f2[i]);
        n_vec++; if (oValid !== 1'b1) begin n_err++; $display("FAIL hold_next_valid: got %0b want 1", oValid); end
        n_vec++; if (oClass !== 4'd4) begin n_err++; $display("FAIL hold_next_oclass: got %0d want 4", oClass); end
        @(negedge clk);
    endtask

    task automatic test_ties();
        oReady = 1'b1;
        for (int i = 0; i < 10; i++) push(22'd4194303);
        n_vec++; if (oValid !== 1'b1) begin n_err++; $display("FAIL ties_ovalid: got %0b want 1", oValid); end
        n_vec++; if (oClass !== 4'd0) begin n_err++; $display("FAIL ties_oclass: got %0d want 0", oClass); end
`ifdef FC3_ARGMAX_SCORE_EN
        n_vec++; if (oScore !== 22'd4194303) begin n_err++; $display("FAIL ties_oscore: got %0d want 4194303", oScore); end
`endif
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [DWID-1:0] junk [4] = '{10, 3000000, 20, 30};
        logic [DWID-1:0] f [10] = '{11, 22, 33, 44, 55, 66, 777, 88, 99, 5};
        oReady = 1'b1;
        for (int i = 0; i < 4; i++) push(junk[i]);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++; if (iReady !== 1'b1) begin n_err++; $display("FAIL mrst_iready: got %0b want 1", iReady); end
        n_vec++; if (oValid !== 1'b0) begin n_err++; $display("FAIL mrst_ovalid: got %0b want 0", oValid); end
        n_vec++; if (oClass !== 4'd0) begin n_err++; $display("FAIL mrst_oclass: got %0d want 0", oClass); end
        for (int i = 0; i < 10; i++) begin
            push(f[i]);
            if (i == 8) begin
                n_vec++; if (oValid !== 1'b0) begin n_err++; $display("FAIL mrst_early_valid: got %0b want 0", oValid); end
            end
        end
        n_vec++; if (oValid !== 1'b1) begin n_err++; $display("FAIL mrst_ovalid_done: got %0b want 1", oValid); end
        n_vec++; if (oClass !== 4'd6) begin n_err++; $display("FAIL mrst_oclass_done: got %0d want 6", oClass); end
        @(negedge clk);
    endtask

    task automatic test_ncls1();
        oReady1 = 1'b1;
        n_vec++; if (iReady1 !== 1'b1) begin n_err++; $display("FAIL n1_iready: got %0b want 1", iReady1); end
        iValid1 = 1'b1; iData1 = 22'd17;
        @(negedge clk);
        iValid1 = 1'b0;
        n_vec++; if (oValid1 !== 1'b1) begin n_err++; $display("FAIL n1_ovalid: got %0b want 1", oValid1); end
        n_vec++; if (oClass1 !== 1'b0) begin n_err++; $display("FAIL n1_oclass: got %0d want 0", oClass1); end
        n_vec++; if (iReady1 !== 1'b0) begin n_err++; $display("FAIL n1_iready_done: got %0b want 0", iReady1); end
`ifdef FC3_ARGMAX_SCORE_EN
        n_vec++; if (oScore1 !== 22'd17) begin n_err++; $display("FAIL n1_oscore: got %0d want 17", oScore1); end
`endif
        @(negedge clk);
        n_vec++; if (oValid1 !== 1'b0) begin n_err++; $display("FAIL n1_pulse: got %0b want 0", oValid1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_hold();
        test_ties();
        test_mid_reset();
        test_ncls1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fc3_argmax.md
FC3_ARGMAX -- requirements
Module: fc3_argmax

Interface
REQ-001 The parameter NCLS SHALL default to 10 and set the number of class scores per frame; the legal range is NCLS >= 1.
REQ-002 The parameter DWID SHALL default to 22 and set the score width, matching the fc3 adder-tree output of 10 + $clog2(3520).
REQ-003 The parameter CWID SHALL default to $clog2(NCLS) with a minimum of 1, and set the class-index width.
REQ-004 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-005 The port rst_n SHALL be an input, 1 bit wide, and be a synchronous, active-low reset.
REQ-006 The port iValid SHALL be an input, 1 bit wide, and indicate that a class score is present on iData.
REQ-007 The port iData SHALL be an input, DWID bits wide, carrying an unsigned class score from the fc3 adder tree.
REQ-008 The port iReady SHALL be an output, 1 bit wide, and indicate that the block accepts a score this cycle.
REQ-009 The port oValid SHALL be an output, 1 bit wide, and indicate that a frame result is present.
REQ-010 The port oClass SHALL be an output, CWID bits wide, carrying the index of the winning class.
REQ-011 The port oReady SHALL be an input, 1 bit wide, and indicate that the consumer takes the result this cycle.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, SCAN and DONE.
REQ-013 A score SHALL be accepted only on a rising edge where iValid=1 and iReady=1.
REQ-014 iReady SHALL be 1 in IDLE and SCAN, and 0 in DONE; iValid in DONE is ignored and no data is lost or counted.
REQ-015 Scores arriving in a frame SHALL be indexed 0..NCLS-1 in order of acceptance, using a CWID-bit counter.
REQ-016 The first accepted score of a frame (IDLE->SCAN) SHALL unconditionally load the running maximum and set the running index to 0.
REQ-017 Each later accepted score SHALL replace the running maximum and index only if it is strictly greater, using an unsigned compare; ties therefore keep the lowest index.
REQ-018 Acceptance of score index NCLS-1 SHALL move the FSM to DONE and reset the counter to 0, with no wrap past NCLS-1.
REQ-019 For NCLS=1, the single accepted score SHALL go directly IDLE->DONE with oClass=0.
REQ-020 oValid SHALL be 1 exactly while in DONE; latency is one cycle from the edge accepting the last score to oValid=1.
REQ-021 oClass SHALL hold stable while oValid=1.
REQ-022 In DONE, an edge with oReady=1 SHALL return the FSM to IDLE; oValid then falls in the next cycle and iReady rises in that same cycle.
REQ-023 In DONE with oReady=0, the FSM SHALL hold indefinitely.
REQ-024 Gaps with iValid=0 in SCAN SHALL hold all state.
REQ-025 The block SHALL contain no combinational path from iValid to iReady or from oReady to oValid.

Reset
REQ-026 While rst_n=0 at a rising edge, the block SHALL force state IDLE, counter 0, running maximum 0 and running index 0.
REQ-027 After reset, oValid=0, oClass=0 and iReady=1 (and oScore=0 when present).
REQ-028 A reset asserted mid-frame (SCAN) or in DONE SHALL discard the partial frame or pending result; the next accepted score is index 0.

Configuration
REQ-029 With macro FC3_ARGMAX_SCORE_EN defined, the block SHALL add output port oScore, DWID bits wide, equal to the running maximum, valid and stable while oValid=1.
REQ-030 With FC3_ARGMAX_SCORE_EN undefined, the oScore port and any logic used only by it SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Scenario: NCLS=10, scores 5,9,3,9,1,0,2,8,7,4 back-to-back, oReady=1 -> oValid pulses 1 cycle after the 10th score, oClass=1 (oScore=9 with macro).
REQ-032 Scenario: ascending scores 0..9 with iValid toggling 1/0 -> oClass=9; iReady stays 1 throughout SCAN.
REQ-033 Scenario: frame complete with oReady=0 for 5 cycles and iValid=1 with data 4000000 -> oValid and oClass held, iReady=0, no score accepted; with oReady=1 the next frame starts at index 0.
REQ-034 Scenario: all ten scores = 4194303 (max DWID) -> oClass=0 (tie rule, no overflow).
REQ-035 Scenario: rst_n=0 for 1 cycle after 4 scores, then a fresh 10-score frame with maximum at index 6 -> oClass=6, first-frame data discarded.
REQ-036 Scenario: NCLS=1, single score 17 -> oValid next cycle, oClass=0.
